// File: rtl/dct16_odd_acc.sv
// dct16_odd_acc: serial odd-row accumulator of the 16-point forward DCT.
// Takes one butterfly difference d[n] = x[n] - x[15-n] per valid cycle (n = 0..7).
// The constant multiplier spiral_8 scales it, and eight sign-routed accumulators
// build rows k = 1, 3, ..., 15. The finished column is presented after the
// 8th sample.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   i_valid   i_data carries a sample this cycle
//   i_data    signed 18-bit d[n], where n is implied by arrival order
//   o_valid   one-cycle pulse: o_data_* hold a new column
//   o_data_k  signed 28-bit odd-row results, k = 1, 3, ..., 15
//
// Parameter SHIFT (1..12) sets the rounding right-shift. It is used only when
// DCT16_ODD_ROUND_EN is defined.
// Configuration macro: DCT16_ODD_ROUND_EN. When it is defined, outputs are
// (sum + 2^(SHIFT-1)) >>> SHIFT. When it is undefined, outputs are full-precision sums.

// spiral_8: shift-add constant multiplier that forms d*{9,25,43,57,70,80,87,90}.
// Products are returned in ascending coefficient order (index 0 = x9, index 7 = x90).
module spiral_8 (
  input  logic signed [17:0]  x_i,
  output logic [7:0][24:0]    prod_o
);
  logic signed [24:0] xe;
  logic signed [24:0] p9, p25, p43, p57, p70, p80, p87, p90;

  always_comb begin
    xe  = 25'(x_i);
    p9  = (xe <<< 3) + xe;
    p25 = (xe <<< 4) + p9;
    p43 = (xe <<< 5) + p9 + (xe <<< 1);
    p57 = (xe <<< 6) - (xe <<< 3) + xe;
    p70 = (xe <<< 6) + (xe <<< 2) + (xe <<< 1);
    p80 = (xe <<< 6) + (xe <<< 4);
    p87 = p80 + (xe <<< 3) - xe;
    p90 = p80 + (xe <<< 3) + (xe <<< 1);
    prod_o = {p90, p87, p80, p70, p57, p43, p25, p9};
  end
endmodule

module dct16_odd_acc #(
  parameter int unsigned SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic signed [17:0] i_data,
  output logic               o_valid,
  output logic signed [27:0] o_data_1,
  output logic signed [27:0] o_data_3,
  output logic signed [27:0] o_data_5,
  output logic signed [27:0] o_data_7,
  output logic signed [27:0] o_data_9,
  output logic signed [27:0] o_data_11,
  output logic signed [27:0] o_data_13,
  output logic signed [27:0] o_data_15
);
  localparam int unsigned AW = 28;
  localparam int unsigned NR = 8;

  logic [NR-1:0][24:0]   prod;
  logic [2:0]            cnt_q, cnt_d;
  logic [NR-1:0][AW-1:0] acc_q, acc_d;
  logic [NR-1:0][AW-1:0] o_data_q, o_data_d;
  logic                  o_valid_q, o_valid_d;

  // Coefficient entry {negate, product index} for row r (k = 2r+1), column n.
  // Each row packs n = 0 in the top nibble.
  function automatic logic [3:0] coef_ent(input logic [2:0] r, input logic [2:0] n);
    logic [31:0] row;
    logic [2:0]  pos;
    case (r)
      3'd0:    row = 32'h7654_3210;
      3'd1:    row = 32'h630A_DFC9;
      3'd2:    row = 32'h50CE_9372;
      3'd3:    row = 32'h4AE0_71DB;
      3'd4:    row = 32'h3D97_8E24;
      3'd5:    row = 32'h2F31_E40D;
      3'd6:    row = 32'h1C7D_20B6;
      default: row = 32'h092B_4D6F;
    endcase
    pos = 3'(3'd7 - n);
    return row[{pos, 2'b00} +: 4];
  endfunction

  // Sign-extended, optionally negated product picked by table entry.
  function automatic logic signed [AW-1:0] pick(input logic [3:0] ent,
                                                input logic [NR-1:0][24:0] p);
    logic signed [AW-1:0] t;
    t = AW'($signed(p[ent[2:0]]));
    return ent[3] ? -t : t;
  endfunction

  // Rounded arithmetic right shift of a completed sum.
  function automatic logic [AW-1:0] round_shift(input logic signed [AW-1:0] s);
    logic signed [AW-1:0] b;
    b = s + AW'(1 << (SHIFT - 1));
    return AW'(b >>> SHIFT);
  endfunction

  function automatic logic [AW-1:0] out_fmt(input logic signed [AW-1:0] s);
`ifdef DCT16_ODD_ROUND_EN
    return round_shift(s);
`else
    return AW'(s);
`endif
  endfunction

  spiral_8 u_spiral (
    .x_i    (i_data),
    .prod_o (prod)
  );

  // Next state: at n = 0, load instead of adding (this drops the previous group).
  // At n = 7, also publish the sum.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    if (i_valid) begin
      cnt_d = cnt_q + 3'd1;
      for (int r = 0; r < int'(NR); r++) begin
        if (cnt_q == 3'd0)
          acc_d[r] = pick(coef_ent(3'(r), cnt_q), prod);
        else
          acc_d[r] = $signed(acc_q[r]) + pick(coef_ent(3'(r), cnt_q), prod);
        if (cnt_q == 3'd7)
          o_data_d[r] = out_fmt($signed(acc_d[r]));
      end
      o_valid_d = (cnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_data_1  = $signed(o_data_q[0]);
  assign o_data_3  = $signed(o_data_q[1]);
  assign o_data_5  = $signed(o_data_q[2]);
  assign o_data_7  = $signed(o_data_q[3]);
  assign o_data_9  = $signed(o_data_q[4]);
  assign o_data_11 = $signed(o_data_q[5]);
  assign o_data_13 = $signed(o_data_q[6]);
  assign o_data_15 = $signed(o_data_q[7]);
endmodule
